// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and the default bit-rate divider.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 434;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmitter bundle between byte sources, the arbiter and the UART transmitter.
// Latency: none, wiring only. req_lock exists only when UART_ARB_LOCK_EN is defined.
// Backpressure: a source holds req until its gnt pulse; tx_busy stalls new grants.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_lock;
`endif
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      src_id;
    logic                 tx_wr_en;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 baud_en;
    logic                 arb_active;
    logic                 err_timeout;

    modport master (
        input  req, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
        input  req_lock,
`endif
        output gnt, src_id, tx_wr_en, tx_data, baud_en, arb_active, err_timeout
    );

    modport slave (
        output req, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
        output req_lock,
`endif
        input  gnt, src_id, tx_wr_en, tx_data, baud_en, arb_active, err_timeout
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-rate tick generator, shared by the UART transmit and receive paths.
// Latency: baud_en_o pulses for one cycle after the counter reaches BAUD_DIV-1.
// Backpressure: none, never stalls.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic baud_en_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          baud_en_q, baud_en_d;

    always_comb begin
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        baud_en_d = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            baud_en_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            baud_en_q <= baud_en_d;
        end
    end

    assign baud_en_o = baud_en_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ sources; UART_ARB_LOCK_EN adds owner lock.
// Latency: req sampled at edge N gives gnt/tx_wr_en in cycle N+1; all outputs registered.
// Backpressure: one byte in flight; next grant only after tx_busy falls or the busy-rise timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BAUD_DIV     = BAUD_DIV_DEFAULT,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    src_id_q, src_id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               tx_wr_en_q, tx_wr_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               err_q, err_d;
    logic               act_q, act_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
`ifdef UART_ARB_LOCK_EN
    logic               own_vld_q, own_vld_d;
`endif

    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] rr_idx;
    logic            rr_found;
    logic [ID_W-1:0] win_idx;
    logic            win_vld;
    logic            win_lock;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .baud_en_o (bus.baud_en)
    );

    // Search upward from ptr; a locked owner pre-empts the search and keeps ptr.
    always_comb begin
        cand     = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!rr_found && bus.req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        win_lock = 1'b0;
`ifdef UART_ARB_LOCK_EN
        win_lock = own_vld_q && bus.req_lock[src_id_q] && bus.req[src_id_q];
`endif
        win_vld = (rr_found || win_lock) && !bus.tx_busy;
        win_idx = win_lock ? src_id_q : rr_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            src_id_q   <= '0;
            gnt_q      <= '0;
            tx_wr_en_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
            act_q      <= 1'b0;
            to_cnt_q   <= '0;
`ifdef UART_ARB_LOCK_EN
            own_vld_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            src_id_q   <= src_id_d;
            gnt_q      <= gnt_d;
            tx_wr_en_q <= tx_wr_en_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            act_q      <= act_d;
            to_cnt_q   <= to_cnt_d;
`ifdef UART_ARB_LOCK_EN
            own_vld_q  <= own_vld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (win_vld) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy)              state_d = WAIT_DONE;
                else if (to_cnt_q == TO_LAST) state_d = IDLE;
            end
            WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = '0;
        tx_wr_en_d = 1'b0;
        err_d      = 1'b0;
        tx_data_d  = tx_data_q;
        src_id_d   = src_id_q;
        ptr_d      = ptr_q;
        to_cnt_d   = to_cnt_q;
`ifdef UART_ARB_LOCK_EN
        own_vld_d  = own_vld_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    tx_wr_en_d     = 1'b1;
                    tx_data_d      = bus.req_data[{win_idx, 3'b000} +: 8];
                    src_id_d       = win_idx;
                    if (!win_lock) ptr_d = ID_W'((int'(win_idx) + 1) % NUM_REQ);
`ifdef UART_ARB_LOCK_EN
                    own_vld_d      = 1'b1;
`endif
                end
            end
            ISSUE: to_cnt_d = '0;
            WAIT_BUSY: begin
                // A transmitter that never goes busy drops the byte rather than wedging the port.
                if (!bus.tx_busy) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LAST) err_d = 1'b1;
                end
            end
            default: ;
        endcase
        act_d = (state_d != IDLE);
    end

    assign bus.gnt         = gnt_q;
    assign bus.src_id      = src_id_q;
    assign bus.tx_wr_en    = tx_wr_en_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.arb_active  = act_q;
    assign bus.err_timeout = err_q;

endmodule
